link_tx: RTL
============

// Module: link_tx
// PURPOSE
//   Transmit side of a router output link. Drains a show-ahead flit FIFO
//   (pop/empty/dout) and drives flits onto the inter-router link.
//   Flow control is credit-based: one credit per free slot in the downstream
//   input FIFO. Tracks packet framing (HEAD/BODY/TAIL) and flags violations.
// PARAMETERS
//   DATA_WIDTH  64                       flit width; bits [DATA_WIDTH-1:DATA_WIDTH-2] = flit type
//   CREDITS     8                        downstream FIFO depth = initial credit count
//   CNT_WIDTH   $clog2(CREDITS+1)        credit counter width
// PORTS
//   clk          in   1           clock, all logic on posedge
//   reset_n      in   1           synchronous, active-low reset
//   fifo_empty   in   1           local FIFO empty
//   fifo_dout    in   DATA_WIDTH  local FIFO head flit, valid when !fifo_empty
//   fifo_pop     out  1           pop local FIFO this cycle
//   link_valid   out  1           link_data carries a flit this cycle
//   link_data    out  DATA_WIDTH  flit to downstream router
//   credit_in    in   1           downstream freed one slot (one credit per high cycle)
//   credits      out  CNT_WIDTH   current credit count
//   tx_active    out  1           mid-packet (state PACKET)
//   framing_err  out  1           sticky: illegal flit-type sequence sent
//   credit_err   out  1           sticky: credit returned while credits == CREDITS
// BEHAVIOUR
//   Flit types (top 2 bits): 00 BODY, 01 HEAD, 10 TAIL, 11 HEAD_TAIL (single-flit packet).
//   Reset (reset_n==0 at posedge): credits=CREDITS, link_valid=0, link_data=0,
//     state=IDLE, framing_err=0, credit_err=0. fifo_pop forced 0 while reset_n==0.
//     Reset mid-packet drops framing state; no flit is popped or sent that cycle.
//   send = reset_n & !fifo_empty & (credits != 0). fifo_pop = send (combinational).
//     A credit arriving in the same cycle does not enable a send in that cycle.
//   Latency: on a send cycle, link_data <= fifo_dout and link_valid <= 1 at the same
//     posedge. Otherwise link_valid <= 0 and link_data holds its value.
//     Back-to-back sends give one flit per cycle.
//   Credits: next = credits - send + credit_in.
//     send & credit_in -> unchanged.
//     credit_in with credits==CREDITS and no send -> saturate at CREDITS, set credit_err.
//     credits never underflows (send requires credits != 0).
//   FSM advances only on send, decoding the type of the flit being popped:
//     IDLE:   HEAD -> PACKET; HEAD_TAIL -> IDLE; BODY/TAIL -> framing_err=1, stay IDLE.
//     PACKET: BODY -> PACKET; TAIL -> IDLE; HEAD -> framing_err=1, stay PACKET;
//             HEAD_TAIL -> framing_err=1, -> IDLE.
//   Flits are always forwarded unmodified, including those that set framing_err.
//   tx_active = (state == PACKET). Error flags clear only on reset.
// TESTING
//   1 Reset; FIFO holds HEAD,BODY,TAIL; credits=8 -> fifo_pop on 3 consecutive cycles;
//     link_valid high for the 3 following cycles with the same flits in order;
//     credits=5; tx_active=1 after HEAD, 0 after TAIL.
//   2 10 flits queued, no credit_in -> exactly 8 sent; credits=0, fifo_pop=0;
//     one credit_in pulse -> credits=1, exactly one more flit the next cycle.
//   3 send and credit_in in the same cycle at credits=3 -> credits stays 3.
//   4 BODY popped in IDLE -> flit still sent; framing_err=1 and stays 1 for the rest of
//     the test; HEAD then HEAD in PACKET -> framing_err stays 1, tx_active=1.
//   5 credit_in at credits=8, no send -> credits=8, credit_err=1.
//   6 After HEAD is sent, reset_n=0 for 1 cycle with FIFO non-empty -> fifo_pop=0 that
//     cycle; then credits=8, link_valid=0, tx_active=0, both error flags 0.

Source files
------------

// File: rtl/link_tx_if.sv
// Router output-link bundle: local show-ahead FIFO read side, link side, credit
// return and status. master = link_tx, slave = the surrounding router.
interface link_tx_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CREDITS    = 8,
    parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_pop;
    logic                  link_valid;
    logic [DATA_WIDTH-1:0] link_data;
    logic                  credit_in;
    logic [CNT_WIDTH-1:0]  credits;
    logic                  tx_active;
    logic                  framing_err;
    logic                  credit_err;

    modport master (
        input  fifo_empty, fifo_dout, credit_in,
        output fifo_pop, link_valid, link_data, credits, tx_active,
               framing_err, credit_err
    );

    modport slave (
        output fifo_empty, fifo_dout, credit_in,
        input  fifo_pop, link_valid, link_data, credits, tx_active,
               framing_err, credit_err
    );
endinterface

// File: rtl/link_tx.sv
// Transmit side of a router output link: drains the local flit FIFO under
// credit-based flow control and checks HEAD/BODY/TAIL packet framing.
module link_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int CREDITS    = 8,
    parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
    input  logic      clk,
    input  logic      reset_n,
    link_tx_if.master bus
);
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        PACKET = 1'b1
    } state_e;

    localparam logic [1:0] T_BODY      = 2'b00;
    localparam logic [1:0] T_HEAD      = 2'b01;
    localparam logic [1:0] T_TAIL      = 2'b10;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);

    logic                  send_s;
    logic [1:0]            flit_type_s;
    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  credits_q, credits_d;
    logic                  link_valid_q, link_valid_d;
    logic [DATA_WIDTH-1:0] link_data_q, link_data_d;
    logic                  framing_err_q, framing_err_d;
    logic                  credit_err_q, credit_err_d;

    // A credit returned this cycle only becomes usable next cycle.
    assign send_s      = reset_n & ~bus.fifo_empty & (credits_q != CNT_ZERO);
    assign flit_type_s = bus.fifo_dout[DATA_WIDTH-1 -: 2];

    // Link register and credit counter next-state.
    always_comb begin
        link_valid_d = send_s;
        link_data_d  = link_data_q;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        if (send_s) begin
            link_data_d = bus.fifo_dout;
        end else begin
            link_data_d = link_data_q;
        end
        case ({send_s, bus.credit_in})
            2'b10: credits_d = credits_q - CNT_ONE;
            2'b01: begin
                if (credits_q == CNT_MAX) begin
                    credit_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CNT_ONE;
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    // Framing FSM: advances only on flits actually popped.
    always_comb begin
        state_d       = state_q;
        framing_err_d = framing_err_q;
        if (send_s) begin
            case (state_q)
                IDLE: begin
                    case (flit_type_s)
                        T_HEAD:  state_d = PACKET;
                        T_BODY,
                        T_TAIL:  framing_err_d = 1'b1;
                        default: state_d = IDLE;
                    endcase
                end
                PACKET: begin
                    case (flit_type_s)
                        T_BODY:  state_d = PACKET;
                        T_TAIL:  state_d = IDLE;
                        T_HEAD:  framing_err_d = 1'b1;
                        default: begin
                            framing_err_d = 1'b1;
                            state_d       = IDLE;
                        end
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            credits_q     <= CNT_MAX;
            link_valid_q  <= 1'b0;
            link_data_q   <= {DATA_WIDTH{1'b0}};
            framing_err_q <= 1'b0;
            credit_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            credits_q     <= credits_d;
            link_valid_q  <= link_valid_d;
            link_data_q   <= link_data_d;
            framing_err_q <= framing_err_d;
            credit_err_q  <= credit_err_d;
        end
    end

    assign bus.fifo_pop    = send_s;
    assign bus.link_valid  = link_valid_q;
    assign bus.link_data   = link_data_q;
    assign bus.credits     = credits_q;
    assign bus.tx_active   = (state_q == PACKET);
    assign bus.framing_err = framing_err_q;
    assign bus.credit_err  = credit_err_q;
endmodule
